// File: rtl/key_debounce.sv
// Debounced push-button front end: per-key synchroniser, stable-time filter,
// sticky press-event register with write-1-to-clear and a maskable level IRQ.
module key_debounce #(
    parameter int unsigned DB_CYCLES  = 250000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        sys_rstn,
    input  logic [7:0]  key_raw,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic [7:0]  key_state,
    output logic        IRQ
);

    localparam logic [7:0]  RELEASED_LVL = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [19:0] CNT_LAST     = 20'(DB_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_EVENT = 2'd1;
    localparam logic [1:0] ADDR_IE    = 2'd2;

    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  sync_n;
    logic [19:0] cnt_q [8];
    logic [19:0] cnt_d [8];
    logic [7:0]  state_q, state_d;
    logic [7:0]  event_q, event_d;
    logic [7:0]  ie_q, ie_d;
    logic        irq_q, irq_d;
    logic [7:0]  clr_mask;
    logic        wr_event, wr_ie;
    logic        unused_din;

    // Upper write-data bits have no destination in this register map.
    assign unused_din = ^Din[31:8];

    // Flops reset to the released pin level so a held key after reset
    // looks like a fresh press and gets filtered again.
    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign sync_n = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_n[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = sync_n[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    assign wr_event = WE && (Addr == ADDR_EVENT);
    assign wr_ie    = WE && (Addr == ADDR_IE);
    assign clr_mask = wr_event ? Din[7:0] : 8'h00;

    // A press accepted on the same edge as a clear of that bit wins.
    assign event_d = (event_q & ~clr_mask) | (state_d & ~state_q);
    assign ie_d    = wr_ie ? Din[7:0] : ie_q;
    assign irq_d   = |(event_q & ie_q);

    always_ff @(posedge clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= '0;
            event_q <= '0;
            ie_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            event_q <= event_d;
            ie_q    <= ie_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (Addr)
            ADDR_STATE: Dout = {24'h0, state_q};
            ADDR_EVENT: Dout = {24'h0, event_q};
            ADDR_IE:    Dout = {24'h0, ie_q};
            default:    Dout = 32'h0;
        endcase
    end

    assign key_state = state_q;
    assign IRQ       = irq_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: window-based reference model feeds a scoreboard queue
// that a negedge monitor drains, plus directed scenario spot checks.
module tb_key_debounce;

    localparam int DB = 4;

    logic        clk;
    logic        sys_rstn;
    logic [7:0]  key_raw;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [7:0]  key_state;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] ks;
        logic [7:0] ev;
        logic [7:0] ie;
        logic       irq;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_s1, m_s2, m_ks, m_ev, m_ie;
    logic       m_irq;
    logic [7:0] shist[$];

    key_debounce #(.DB_CYCLES(DB), .ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .sys_rstn  (sys_rstn),
        .key_raw   (key_raw),
        .Addr      (Addr),
        .WE        (WE),
        .Din       (Din),
        .Dout      (Dout),
        .key_state (key_state),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_model(input exp_t e, input logic [1:0] a);
        case (a)
            2'd0:    return {24'h0, e.ks};
            2'd1:    return {24'h0, e.ev};
            2'd2:    return {24'h0, e.ie};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1  = 8'hFF;
        m_s2  = 8'hFF;
        m_ks  = 8'h00;
        m_ev  = 8'h00;
        m_ie  = 8'h00;
        m_irq = 1'b0;
        shist.delete();
    endtask

    // A key flips once the last DB synchronised samples all disagree with it.
    task automatic model_step();
        logic [7:0] nks;
        logic [7:0] clr;
        logic       all_diff;
        exp_t       e;
        if (!sys_rstn) begin
            model_reset();
        end else begin
            shist.push_back(~m_s2);
            if (shist.size() > DB) void'(shist.pop_front());
            nks = m_ks;
            if (shist.size() == DB) begin
                for (int i = 0; i < 8; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < shist.size(); j++)
                        if (shist[j][i] == m_ks[i]) all_diff = 1'b0;
                    if (all_diff) nks[i] = ~m_ks[i];
                end
            end
            clr   = (WE && Addr == 2'd1) ? Din[7:0] : 8'h00;
            m_irq = |(m_ev & m_ie);
            m_ev  = (m_ev & ~clr) | (nks & ~m_ks);
            if (WE && Addr == 2'd2) m_ie = Din[7:0];
            m_ks = nks;
            m_s2 = m_s1;
            m_s1 = key_raw;
        end
        e.ks = m_ks; e.ev = m_ev; e.ie = m_ie; e.irq = m_irq;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        cyc();
        WE   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(nm, Dout, exp);
    endtask

    task automatic assert_reset();
        exp_t z;
        sys_rstn = 1'b0;
        model_reset();
        z.ks = 8'h00; z.ev = 8'h00; z.ie = 8'h00; z.irq = 1'b0;
        if (sb.size() > 0) sb[sb.size()-1] = z;
        #1;
        chk("rst_key_state", 32'(key_state), 32'h0);
        chk("rst_irq", 32'(IRQ), 32'h0);
        chk("rst_dout", Dout, 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_key_state", 32'(key_state), 32'(e.ks));
                chk("sb_irq", 32'(IRQ), 32'(e.irq));
                chk("sb_dout", Dout, rd_model(e, Addr));
            end
        end
    end

    initial begin : driver
        sys_rstn = 1'b0;
        key_raw  = 8'hFF;
        Addr     = 2'd0;
        WE       = 1'b0;
        Din      = 32'h0;
        model_reset();
        repeat (3) cyc();
        sys_rstn = 1'b1;
        repeat (2) cyc();

        // clean press and release of key 0
        wr(2'd2, 32'h01);
        key_raw = 8'hFE;
        repeat (5) cyc();
        chk("press_edge5", 32'(key_state), 32'h00);
        cyc();
        chk("press_edge6", 32'(key_state), 32'h01);
        chk("irq_edge6", 32'(IRQ), 32'h0);
        cyc();
        chk("irq_edge7", 32'(IRQ), 32'h1);
        rd_chk("press_event", 2'd1, 32'h01);
        key_raw = 8'hFF;
        repeat (5) cyc();
        chk("release_edge5", 32'(key_state), 32'h01);
        cyc();
        chk("release_edge6", 32'(key_state), 32'h00);
        rd_chk("release_event", 2'd1, 32'h01);

        // bounce on key 3 never accepted
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h08);
        for (int k = 0; k < 10; k++) begin
            key_raw = (k % 2 == 0) ? 8'hF7 : 8'hFF;
            repeat (2) cyc();
        end
        key_raw = 8'hFF;
        repeat (8) cyc();
        chk("bounce_state", 32'(key_state), 32'h00);
        chk("bounce_irq", 32'(IRQ), 32'h0);
        rd_chk("bounce_event", 2'd1, 32'h00);

        // clear of bit 2 on the same edge key 2 is accepted
        wr(2'd2, 32'h04);
        key_raw = 8'hFB;
        repeat (5) cyc();
        Addr = 2'd1; Din = 32'h04; WE = 1'b1;
        cyc();
        WE = 1'b0;
        rd_chk("collide_event", 2'd1, 32'h04);
        cyc();
        chk("collide_irq", 32'(IRQ), 32'h1);
        wr(2'd1, 32'h04);
        rd_chk("clear_event", 2'd1, 32'h00);
        chk("clear_irq_write_edge", 32'(IRQ), 32'h1);
        cyc();
        chk("clear_irq_next_edge", 32'(IRQ), 32'h0);
        key_raw = 8'hFF;
        repeat (8) cyc();

        // masking on key 5
        wr(2'd2, 32'h00);
        key_raw = 8'hDF;
        repeat (8) cyc();
        chk("mask_irq_off", 32'(IRQ), 32'h0);
        rd_chk("mask_event", 2'd1, 32'h20);
        wr(2'd2, 32'h20);
        chk("unmask_write_edge", 32'(IRQ), 32'h0);
        cyc();
        chk("unmask_next_edge", 32'(IRQ), 32'h1);
        wr(2'd2, 32'h00);
        chk("remask_write_edge", 32'(IRQ), 32'h1);
        cyc();
        chk("remask_next_edge", 32'(IRQ), 32'h0);
        key_raw = 8'hFF;
        repeat (8) cyc();

        // keys 0 and 7 together, register decode
        wr(2'd1, 32'hFF);
        key_raw = 8'h7E;
        repeat (5) cyc();
        chk("multi_edge5", 32'(key_state), 32'h00);
        cyc();
        chk("multi_edge6", 32'(key_state), 32'h81);
        rd_chk("multi_state_rd", 2'd0, 32'h81);
        rd_chk("addr3_rd", 2'd3, 32'h0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("state_write_ignored", 2'd0, 32'h81);
        rd_chk("multi_event", 2'd1, 32'h81);
        key_raw = 8'hFF;
        repeat (8) cyc();

        // reset while key 1 is mid-filter
        key_raw = 8'hFD;
        repeat (4) cyc();
        assert_reset();
        repeat (3) cyc();
        sys_rstn = 1'b1;
        repeat (5) cyc();
        chk("rst_refilter_edge5", 32'(key_state), 32'h00);
        cyc();
        chk("rst_refilter_edge6", 32'(key_state), 32'h02);
        rd_chk("rst_refilter_event", 2'd1, 32'h02);
        key_raw = 8'hFF;
        repeat (8) cyc();

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 5) == 0)
                key_raw = key_raw ^ (8'h01 << $urandom_range(0, 7));
            Addr = 2'($urandom_range(0, 3));
            Din  = $urandom;
            WE   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 999) == 0) begin
                WE = 1'b0;
                assert_reset();
                repeat (2) cyc();
                sys_rstn = 1'b1;
            end
            cyc();
        end
        WE = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
